// File: rtl/rom_stream_pkg.sv
// Shared types for the ROM sweep engine.
//   mode_e  : sweep pattern latched on an accepted start (encoding 3 is reserved)
//   state_e : control FSM states, also exported on the debug state port
//   CHECKSUM_W : width of the optional output checksum
package rom_stream_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int CHECKSUM_W = 16;

endpackage

// File: rtl/rom_stream_reader_if.sv
// Output stream bundle of the ROM sweep engine.
//   m_valid : producer has a word on m_data/m_addr
//   m_ready : consumer can take a word this clock
//   m_data  : ROM word
//   m_addr  : address the word was read from
// Handshake: a beat transfers on every rising clk edge where m_valid and
// m_ready are both high. Once m_valid is raised it stays high, and m_data /
// m_addr stay unchanged, until that beat transfers. m_valid never depends
// on m_ready; m_ready may depend on m_valid.
interface rom_stream_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;

  modport master (
    output m_valid,
    output m_data,
    output m_addr,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_addr,
    output m_ready
  );

endinterface

// File: rtl/rom_stream_fifo.sv
// Synchronous FIFO holding {addr, data} words between the ROM read pipe and
// the output stream. Read data comes straight from storage, so the head entry
// is a registered value.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push/wdata : write one entry (ignored when full and not popping)
//   pop        : remove head entry (ignored when empty)
//   rdata      : head entry, meaningful while !empty
//   empty      : no entries
//   count      : current occupancy, 0..DEPTH
// Push and pop in the same clock while full is allowed; occupancy stays put.
// DEPTH must be a power of two and at least 2.
module rom_stream_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/rom_stream_reader.sv
// ROM sweep engine: reads a programmable address window from a synchronous
// ROM and streams {data, addr} over a valid/ready interface. Modes: single
// pass, endless loop, endless ping-pong. Reads are credit limited so the
// output FIFO can never overflow, whatever the consumer backpressure.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, stop       : 1-clk command pulses (stop wins when both are high)
//   mode, start_addr,
//   end_addr          : window and pattern, latched on an accepted start
//   rom_addr / rom_q  : ROM IP port, rom_q valid ROM_LAT clocks after rom_addr
//   m_if              : output stream (master side)
//   busy, done, err   : status; done and err are 1-clk pulses
//   checksum          : 16-bit sum of accepted m_data when ROM_CHECKSUM_EN is
//                       defined, otherwise constant zero
//   dbg_state         : current FSM state
// Build option: define ROM_CHECKSUM_EN to include the checksum accumulator.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_q,
  rom_stream_reader_if.master   m_if,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CHECKSUM_W-1:0] checksum,
  output state_e                dbg_state
);

  localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CR_W   = $clog2(FIFO_DEPTH + ROM_LAT + 2) + 1;
  localparam int BEAT_W = ADDR_W + DATA_W;

  state_e state, state_d;

  // Latched sweep parameters and address generator state.
  mode_e             mode_q;
  logic [ADDR_W-1:0] s_q, e_q, nxt_q;
  logic              dir_q;          // ping-pong direction, 1 = descending

  // Read pipe: the issue register (rom_addr) followed by ROM_LAT tag stages.
  logic                            iss_v;
  logic [ROM_LAT-1:0]              pipe_v;
  logic [ROM_LAT-1:0][ADDR_W-1:0]  pipe_a;

  logic [CR_W-1:0]   inflight;
  logic [OCC_W-1:0]  occ;
  logic              have_credit;
  logic              win_ok;

  logic              issue, accept, reject, finish;

  logic [ADDR_W-1:0] cur_a, cur_s, cur_e, gen_a;
  mode_e             cur_m;
  logic              cur_dir, gen_dir, gen_last;

  logic              fifo_push, fifo_pop, fifo_empty;
  logic [BEAT_W-1:0] fifo_wdata, fifo_rdata;

  // Reads in flight: the issue stage plus every occupied tag stage.
  always_comb begin
    inflight = CR_W'(iss_v);
    for (int k = 0; k < ROM_LAT; k++) inflight = inflight + CR_W'(pipe_v[k]);
  end

  // A read may issue only if its word is guaranteed a FIFO slot.
  assign have_credit = (CR_W'(occ) + inflight) < CR_W'(FIFO_DEPTH);
  assign win_ok      = (start_addr <= end_addr) && (mode != 2'd3);

  // In IDLE the first read comes straight from the command inputs so the
  // first word is issued in the same clock the start is accepted.
  always_comb begin
    if (state == IDLE) begin
      cur_a   = start_addr;
      cur_s   = start_addr;
      cur_e   = end_addr;
      cur_m   = mode_e'(mode);
      cur_dir = 1'b0;
    end else begin
      cur_a   = nxt_q;
      cur_s   = s_q;
      cur_e   = e_q;
      cur_m   = mode_q;
      cur_dir = dir_q;
    end
  end

  // Address following cur_a. The window never wraps past end_addr, so the
  // +1 / -1 below never cross the modulo boundary inside a valid window.
  always_comb begin
    gen_a    = cur_a + ADDR_W'(1);
    gen_dir  = cur_dir;
    gen_last = 1'b0;
    case (cur_m)
      MODE_SINGLE: gen_last = (cur_a == cur_e);
      MODE_LOOP: begin
        if (cur_a == cur_e) gen_a = cur_s;
      end
      MODE_PINGPONG: begin
        if (cur_s == cur_e) begin
          gen_a = cur_a;
        end else if (!cur_dir) begin
          if (cur_a == cur_e) begin
            gen_a   = cur_a - ADDR_W'(1);
            gen_dir = 1'b1;
          end
        end else if (cur_a == cur_s) begin
          gen_a   = cur_a + ADDR_W'(1);
          gen_dir = 1'b0;
        end else begin
          gen_a = cur_a - ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // FSM next state and per-clock controls.
  always_comb begin
    state_d = state;
    issue   = 1'b0;
    accept  = 1'b0;
    reject  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (win_ok) begin
            accept  = 1'b1;
            issue   = 1'b1;
            state_d = gen_last ? DRAIN : RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (have_credit) begin
          issue = 1'b1;
          if (gen_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep parameters, address generator and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_SINGLE;
      s_q    <= '0;
      e_q    <= '0;
      nxt_q  <= '0;
      dir_q  <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= mode_e'(mode);
        s_q    <= start_addr;
        e_q    <= end_addr;
      end
      if (issue) begin
        nxt_q <= gen_a;
        dir_q <= gen_dir;
      end
      err  <= reject;
      done <= finish;
    end
  end

  // Read pipe: tags shift alongside the ROM's internal latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v    <= 1'b0;
      rom_addr <= '0;
      pipe_v   <= '0;
      pipe_a   <= '0;
    end else begin
      iss_v <= issue;
      if (issue) rom_addr <= cur_a;
      pipe_v[0] <= iss_v;
      pipe_a[0] <= rom_addr;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_a[k] <= pipe_a[k-1];
      end
    end
  end

  assign fifo_push  = pipe_v[ROM_LAT-1];
  assign fifo_wdata = {pipe_a[ROM_LAT-1], rom_q};
  assign fifo_pop   = m_if.m_valid && m_if.m_ready;

  rom_stream_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (occ)
  );

  // Outputs are forced to zero while no word is held.
  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
  assign m_if.m_addr  = fifo_empty ? '0 : fifo_rdata[BEAT_W-1:DATA_W];
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (fifo_pop) begin
      checksum <= checksum + CHECKSUM_W'(fifo_rdata[DATA_W-1:0]);
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a behavioural ROM
// (rom[a] = a*3 mod 256) of latency ROM_LAT. Expected beats are queued in
// exp_q before each sweep and compared in order as they are accepted.
module tb_rom_stream_reader;
  import rom_stream_pkg::*;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 8;
  localparam int ROM_LAT    = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int BEAT_W     = ADDR_W + DATA_W;

`ifdef ROM_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM_T1 = 16'h002A;
  localparam logic [15:0] EXP_SUM_T4 = 16'h05D0;
`else
  localparam logic [15:0] EXP_SUM_T1 = 16'h0000;
  localparam logic [15:0] EXP_SUM_T4 = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic [1:0]        mode  = 2'd0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr   = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              busy, done, err;
  logic [15:0]       checksum;
  state_e            dbg_state;

  rom_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

  rom_stream_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .ROM_LAT    (ROM_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .m_if       (m_if),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum),
    .dbg_state  (dbg_state)
  );

  // ---------------- behavioural ROM ----------------
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    int v;
    v = int'(a) * 3;
    return DATA_W'(v % 256);
  endfunction

  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_word(rom_addr);
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  // ---------------- scoreboard ----------------
  logic [BEAT_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int beat_cnt = 0;
  int last_beat_edge = 0;
  logic              hold_pending = 1'b0;
  logic [BEAT_W-1:0] hold_beat = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge: a beat seen here transfers on the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending)
        check("hold_stable", 32'({m_if.m_valid, m_if.m_addr, m_if.m_data}),
              32'({1'b1, hold_beat}));
      if (m_if.m_valid && m_if.m_ready) begin
        beat_cnt++;
        last_beat_edge = cyc + 1;
        check("beat_expected_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("beat", 32'({m_if.m_addr, m_if.m_data}), 32'(exp_q.pop_front()));
      end
      hold_pending = m_if.m_valid && !m_if.m_ready;
      hold_beat    = {m_if.m_addr, m_if.m_data};
    end else begin
      hold_pending = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a);
    exp_q.push_back({ADDR_W'(a), rom_word(ADDR_W'(a))});
  endtask

  task automatic pulse_start(input int m, input int s, input int e);
    mode       = 2'(m);
    start_addr = ADDR_W'(s);
    end_addr   = ADDR_W'(e);
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (beat_cnt < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(beat_cnt >= n), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rand_ready,
                           output int done_edge);
    int k;
    k = 0;
    while (!done && k < budget) begin
      if (rand_ready) m_if.m_ready = ($urandom_range(0, 9) < 3);
      step();
      k++;
    end
    done_edge = cyc;
    check(tag, 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int dedge;
    int pp[6];
    pp = '{0, 1, 2, 3, 2, 1};
    m_if.m_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_valid", 32'(m_if.m_valid), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // 1: single pass 2..5, consumer always ready
    m_if.m_ready = 1'b1;
    beat_cnt = 0;
    for (int a = 2; a <= 5; a++) push_exp(a);
    pulse_start(0, 2, 5);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state_run", 32'(dbg_state), 32'(RUN));
    lat = 0;
    while (!m_if.m_valid && lat < 20) begin
      step();
      lat++;
    end
    check("t1_first_valid_latency", 32'(lat), 32'(ROM_LAT + 1));
    wait_done("t1_done", 50, 1'b0, dedge);
    check("t1_done_after_last_beat", 32'(dedge - last_beat_edge), 32'd1);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check("t1_beats", 32'(beat_cnt), 32'd4);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_checksum", 32'(checksum), 32'(EXP_SUM_T1));
    step();
    check("t1_done_one_clk", 32'(done), 32'd0);

    // 2: loop 30..31, stop after 5 beats
    beat_cnt = 0;
    for (int i = 0; i < 20; i++) push_exp(30 + (i % 2));
    pulse_start(1, 30, 31);
    wait_beats("t2_five_beats", 5, 100);
    pulse_stop();
    check("t2_draining", 32'(dbg_state), 32'(DRAIN));
    wait_done("t2_done", 50, 1'b0, dedge);
    check("t2_beats_bounded", 32'(beat_cnt >= 5 && beat_cnt <= 6 + FIFO_DEPTH), 32'd1);
    exp_q.delete();
    step();

    // 3: ping-pong 0..3 (no repeats at the turns)
    beat_cnt = 0;
    for (int i = 0; i < 30; i++) push_exp(pp[i % 6]);
    pulse_start(2, 0, 3);
    wait_beats("t3_twelve_beats", 12, 100);
    pulse_stop();
    wait_done("t3_done", 50, 1'b0, dedge);
    check("t3_beats_bounded", 32'(beat_cnt >= 12 && beat_cnt <= 13 + FIFO_DEPTH), 32'd1);
    exp_q.delete();
    step();

    // 3b: one-address windows
    beat_cnt = 0;
    for (int i = 0; i < 16; i++) push_exp(17);
    pulse_start(2, 17, 17);
    wait_beats("t3b_pp_single_addr", 6, 100);
    pulse_stop();
    wait_done("t3b_pp_done", 50, 1'b0, dedge);
    exp_q.delete();
    beat_cnt = 0;
    push_exp(31);
    pulse_start(0, 31, 31);
    wait_done("t3b_single_done", 50, 1'b0, dedge);
    check("t3b_single_beats", 32'(beat_cnt), 32'd1);
    check("t3b_single_queue_empty", 32'(exp_q.size()), 32'd0);
    step();

    // 4: full window with ~30% ready duty
    beat_cnt = 0;
    m_if.m_ready = 1'b0;
    for (int a = 0; a < 32; a++) push_exp(a);
    pulse_start(0, 0, 31);
    wait_done("t4_done", 3000, 1'b1, dedge);
    m_if.m_ready = 1'b1;
    check("t4_beats", 32'(beat_cnt), 32'd32);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t4_checksum", 32'(checksum), 32'(EXP_SUM_T4));
    step();

    // 5: rejected starts, start+stop together, start while busy
    beat_cnt = 0;
    pulse_start(0, 9, 4);
    check("t5_bad_window_err", 32'(err), 32'd1);
    check("t5_bad_window_busy", 32'(busy), 32'd0);
    step();
    check("t5_err_one_clk", 32'(err), 32'd0);
    pulse_start(3, 1, 2);
    check("t5_mode3_err", 32'(err), 32'd1);
    check("t5_mode3_busy", 32'(busy), 32'd0);
    mode = 2'd0; start_addr = 5'd1; end_addr = 5'd2;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("t5_start_stop_busy", 32'(busy), 32'd0);
    check("t5_start_stop_err", 32'(err), 32'd0);
    step();
    step();
    check("t5_no_beats", 32'(beat_cnt), 32'd0);
    for (int i = 0; i < 20; i++) push_exp(5 + (i % 2));
    pulse_start(1, 5, 6);
    step();
    step();
    pulse_start(0, 10, 10);
    check("t5_busy_start_no_err", 32'(err), 32'd0);
    check("t5_busy_start_busy", 32'(busy), 32'd1);
    wait_beats("t5_stream_continues", 6, 100);
    pulse_stop();
    wait_done("t5_done", 50, 1'b0, dedge);
    exp_q.delete();
    step();

    // 6: asynchronous reset mid-sweep, then a fresh sweep
    beat_cnt = 0;
    for (int i = 0; i < 30; i++) push_exp(7 + (i % 3));
    pulse_start(1, 7, 9);
    wait_beats("t6_beats_before_reset", 4, 100);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(m_if.m_valid), 32'd0);
    check("t6_data_addr", 32'({m_if.m_addr, m_if.m_data}), 32'd0);
    check("t6_rom_addr", 32'(rom_addr), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    check("t6_checksum", 32'(checksum), 32'd0);
    exp_q.delete();
    step();
    check("t6_no_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    beat_cnt = 0;
    for (int a = 7; a <= 9; a++) push_exp(a);
    pulse_start(0, 7, 9);
    wait_done("t6_fresh_done", 50, 1'b0, dedge);
    check("t6_fresh_beats", 32'(beat_cnt), 32'd3);
    check("t6_fresh_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
